// File: rtl/p_decoder_pkg.sv
// Shared types and helpers for the request-side 1-to-2 address decoder.
package p_decoder_pkg;

  // Decoder FSM states, tracking outstanding traffic toward one slave.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } dec_state_e;

  // Slave index: 0 = default slave, 1 = address-matched slave.
  typedef logic tgt_t;

  // Width of a counter that must hold 0..max_outst inclusive.
  function automatic int cnt_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/p_decoder_outst_cnt.sv
// Up/down saturating counter of outstanding requests.
// A simultaneous inc and dec leaves the count unchanged.
module outst_cnt
  import p_decoder_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = cnt_width(MAX_OUTST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step only on a lone inc or dec, clamped to 0..MAX_OUTST.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/p_decoder.sv
// Request-side 1-to-2 address decoder. Steers one master's requests to
// slave 0 or 1 by address. It never switches slave while responses from
// the current slave are outstanding, so per-master response order holds.
module p_decoder
  import p_decoder_pkg::*;
#(
  parameter int                DATA_SIZE = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] SLV1_BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SLV1_MASK = 32'hF000_0000,
  parameter int                MAX_OUTST = 4
) (
  input  logic                 AXI_CLK_i,
  input  logic                 AXI_RSTn_i,
  input  logic [DATA_SIZE-1:0] in,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic                 in_valid,
  output logic                 in_grant,
  output logic [DATA_SIZE-1:0] out0,
  output logic [DATA_SIZE-1:0] out1,
  output logic                 out0_valid,
  output logic                 out1_valid,
  input  logic                 out0_grant,
  input  logic                 out1_grant,
  input  logic                 rsp0_done,
  input  logic                 rsp1_done,
  output logic                 sel,
  output logic                 busy,
  output logic                 err
);

  localparam int               CNT_W   = cnt_width(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  dec_state_e       state_q, state_d;
  tgt_t             cur_tgt_q, cur_tgt_d;
  logic             err_q, err_d;
  tgt_t             tgt;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             cnt_zero, cnt_full;
  logic             blocked, switch_req, accept;
  logic             done_cur, done_ok, done_bad;

  // Address decode: a masked match selects slave 1, anything else slave 0.
  assign tgt = ((in_addr & SLV1_MASK) == SLV1_BASE);
  assign sel = tgt;

  // A request to the other slave must wait until the current slave drains.
  assign switch_req = in_valid && !cnt_zero && (tgt != cur_tgt_q);
  assign blocked    = (!cnt_zero && (tgt != cur_tgt_q)) || cnt_full;

  // Valids and grant are gated directly by reset so they drop immediately.
  assign out0_valid = AXI_RSTn_i && in_valid && (tgt == 1'b0) && !blocked;
  assign out1_valid = AXI_RSTn_i && in_valid && (tgt == 1'b1) && !blocked;
  assign in_grant   = (out0_valid && out0_grant) || (out1_valid && out1_grant);
  assign accept     = in_valid && in_grant;

  // Only a completion from the current slave with work pending counts.
  assign done_cur = cur_tgt_q ? rsp1_done : rsp0_done;
  assign done_ok  = done_cur && !cnt_zero;
  assign done_bad = cnt_zero ? (rsp0_done || rsp1_done)
                             : (cur_tgt_q ? rsp0_done : rsp1_done);

  assign out0 = in;
  assign out1 = in;
  assign busy = !cnt_zero;
  assign err  = err_q;

  outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_outst_cnt (
    .clk    (AXI_CLK_i),
    .rst_n  (AXI_RSTn_i),
    .inc_i  (accept),
    .dec_i  (done_ok),
    .cnt_o  (cnt),
    .zero_o (cnt_zero),
    .full_o (cnt_full)
  );

  // Count the counter will hold after this edge; drives FSM transitions.
  always_comb begin
    cnt_next = cnt;
    if (accept && !done_ok) begin
      cnt_next = cnt + CNT_W'(1);
    end else if (done_ok && !accept) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  // FSM next state: occupancy picks IDLE/BUSY/FULL, a held switch picks DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (cnt_next == CNT_MAX) ? FULL : BUSY;
        end
      end
      default: begin
        if (cnt_next == '0) begin
          state_d = IDLE;
        end else if (cnt_next == CNT_MAX) begin
          state_d = FULL;
        end else if (switch_req) begin
          state_d = DRAIN;
        end else begin
          state_d = BUSY;
        end
      end
    endcase
  end

  // Current target follows each accepted request; err is sticky until reset.
  always_comb begin
    cur_tgt_d = accept ? tgt : cur_tgt_q;
    err_d     = err_q | done_bad;
  end

  // State, current target and error flag registers.
  always_ff @(posedge AXI_CLK_i or negedge AXI_RSTn_i) begin
    if (!AXI_RSTn_i) begin
      state_q   <= IDLE;
      cur_tgt_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_tgt_q <= cur_tgt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_p_decoder.sv
// Self-checking bench for p_decoder: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against
// a model of the outstanding set (count + shared target).
module tb_p_decoder;
  import p_decoder_pkg::*;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          MAX  = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] MASK = 32'hF000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic          in_valid, g0, g1, d0, d1;
  logic          in_grant, o0v, o1v, sel, busy, err;
  logic [DW-1:0] o0, o1;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: number of outstanding requests, the slave they all went to, sticky error.
  int m_cnt    = 0;
  bit m_tgt    = 1'b0;
  bit m_err    = 1'b0;
  bit last_acc = 1'b0;

  always #5 clk = ~clk;

  p_decoder #(
    .DATA_SIZE (DW),
    .ADDR_W    (AW),
    .SLV1_BASE (BASE),
    .SLV1_MASK (MASK),
    .MAX_OUTST (MAX)
  ) dut (
    .AXI_CLK_i  (clk),
    .AXI_RSTn_i (rst_n),
    .in         (din),
    .in_addr    (addr),
    .in_valid   (in_valid),
    .in_grant   (in_grant),
    .out0       (o0),
    .out1       (o1),
    .out0_valid (o0v),
    .out1_valid (o1v),
    .out0_grant (g0),
    .out1_grant (g1),
    .rsp0_done  (d0),
    .rsp1_done  (d1),
    .sel        (sel),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dec_tgt(input logic [AW-1:0] a);
    return (a & MASK) == BASE;
  endfunction

  // Slave n may see the request if it is the target and the outstanding set allows it.
  function automatic bit exp_v(input bit n);
    bit t;
    bit may_issue;
    t         = dec_tgt(addr);
    may_issue = (m_cnt == 0 || t == m_tgt) && m_cnt < MAX;
    return rst_n && in_valid && (t == n) && may_issue;
  endfunction

  function automatic bit exp_grant();
    return (exp_v(1'b0) && g0) || (exp_v(1'b1) && g1);
  endfunction

  // Model update at each edge; reset wipes everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      m_tgt    <= 1'b0;
      m_err    <= 1'b0;
      last_acc <= 1'b0;
    end else begin
      bit acc;
      bit ok;
      bit bad;
      acc = in_valid && exp_grant();
      ok  = (m_cnt > 0) && (m_tgt ? d1 : d0);
      bad = (m_cnt == 0) ? (d0 || d1) : (m_tgt ? d0 : d1);
      m_cnt <= m_cnt + (acc ? 1 : 0) - (ok ? 1 : 0);
      if (acc) m_tgt <= dec_tgt(addr);
      if (bad) m_err <= 1'b1;
      last_acc <= acc;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out0_valid", o0v, exp_v(1'b0));
      check("out1_valid", o1v, exp_v(1'b1));
      check("in_grant", in_grant, exp_grant());
      check("sel", sel, dec_tgt(addr));
      check("busy", busy, m_cnt != 0);
      check("err", err, m_err);
      check("out0", o0, din);
      check("out1", o1, din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    din = '0; addr = '0; in_valid = 0; g0 = 0; g1 = 0; d0 = 0; d1 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_o0v", o0v, 0);
    check("rst_o1v", o1v, 0);
    check("rst_grant", in_grant, 0);

    // Decode to slave 1 with zero-latency grant, busy on the next cycle.
    tick(); addr = 32'h1000_0040; din = 32'hA5A5_0001; in_valid = 1; g1 = 1;
    @(negedge clk);
    check("dec1_o1v", o1v, 1);
    check("dec1_o0v", o0v, 0);
    check("dec1_sel", sel, 1);
    check("dec1_grant", in_grant, 1);
    check("dec1_out1", o1, 32'hA5A5_0001);
    tick(); in_valid = 0; g1 = 0;
    @(negedge clk);
    check("dec1_busy", busy, 1);
    tick(); d1 = 1;
    tick(); d1 = 0;
    @(negedge clk);
    check("dec1_idle", busy, 0);
    check("dec1_err", err, 0);

    // Decode to slave 0, then fill to MAX and check the block.
    tick(); addr = 32'h2000_0000; din = 32'h5A5A_0002; in_valid = 1; g0 = 1;
    @(negedge clk);
    check("dec0_o0v", o0v, 1);
    check("dec0_o1v", o1v, 0);
    check("dec0_sel", sel, 0);
    repeat (4) tick();
    @(negedge clk);
    check("full_grant", in_grant, 0);
    check("full_o0v", o0v, 0);
    check("full_state", dut.state_q, FULL);
    tick(); d0 = 1;
    tick(); d0 = 0;
    @(negedge clk);
    check("full_resume", in_grant, 1);
    tick(); in_valid = 0;

    // Switch: drain two slave-0 requests before slave 1 may issue.
    d0 = 1; repeat (2) tick(); d0 = 0;
    addr = 32'h1000_0000; din = 32'h0000_1111; in_valid = 1; g1 = 1;
    @(negedge clk);
    check("sw_o1v", o1v, 0);
    check("sw_grant", in_grant, 0);
    tick();
    @(negedge clk);
    check("sw_state", dut.state_q, DRAIN);
    tick(); d0 = 1; repeat (2) tick(); d0 = 0;
    @(negedge clk);
    check("sw_issue", o1v, 1);
    check("sw_idle", dut.state_q, IDLE);

    // Simultaneous accept and completion keeps the count at 2.
    tick();
    tick(); d1 = 1;
    tick(); in_valid = 0; d1 = 0;
    tick(); d1 = 1;
    tick(); d1 = 0;
    @(negedge clk);
    check("sim_cnt_not_1", busy, 1);
    tick(); d1 = 1;
    tick(); d1 = 0;
    @(negedge clk);
    check("sim_cnt_0", busy, 0);

    // Unexpected completions set a sticky error without touching the count.
    tick(); d1 = 1;
    tick(); d1 = 0;
    @(negedge clk);
    check("err_idle", err, 1);
    check("err_idle_busy", busy, 0);
    tick(); addr = 32'h2000_0010; in_valid = 1; g0 = 1;
    tick(); in_valid = 0;
    tick(); d1 = 1;
    tick(); d1 = 0;
    @(negedge clk);
    check("err_sticky", err, 1);
    check("err_cnt_kept", busy, 1);
    tick(); d0 = 1;
    tick(); d0 = 0;
    @(negedge clk);
    check("err_drained", busy, 0);

    // Asynchronous reset mid-burst clears everything immediately.
    tick(); in_valid = 1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("arst_o0v", o0v, 0);
    check("arst_grant", in_grant, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    tick(); rst_n = 1'b1; in_valid = 0;

    // Randomized traffic; the master holds its request until granted.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      if (!(in_valid && !last_acc)) begin
        logic [AW-1:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[31:28] = 4'h1;
        else if (a[31:28] == 4'h1) a[31:28] = 4'h3;
        addr     = a;
        din      = $urandom;
        in_valid = ($urandom_range(0, 99) < 60);
      end
      g0 = ($urandom_range(0, 99) < 70);
      g1 = ($urandom_range(0, 99) < 70);
      d0 = 0;
      d1 = 0;
      if (m_cnt != 0 && $urandom_range(0, 99) < 35) begin
        if (m_tgt) d1 = 1;
        else d0 = 1;
      end
    end

    tick(); in_valid = 0; d0 = 0; d1 = 0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
